// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the clk_div_gen divider family.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF       = 16;
    localparam int unsigned DEFAULT_DIV_DEF = 2;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // A ratio of zero has no meaningful period, so it behaves as divide-by-one.
    function automatic int unsigned clamp_div(input int unsigned div);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, current/pending ratio and registered outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             clkdv,
    output logic             ce
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             act_q;
    logic             clkdv_q, clkdv_d;
    logic             ce_q, ce_d;
    logic [DIV_W-1:0] div_clamped;
    logic             boundary;

    assign div_clamped = DIV_W'(clamp_div(32'(div)));

    // A period boundary is either the wrap cycle or the first cycle after being idle.
    assign boundary = !act_q || (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        cnt_d    = '0;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clkdv_d  = 1'b0;
        ce_d     = 1'b0;

        if (!run || boundary) begin
            if (load) begin
                div_d = div_clamped;
            end else if (pend_v_q) begin
                div_d = pend_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = div_clamped;
            pend_v_d = 1'b1;
        end

        if (run && !boundary) begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // Outputs are registered from the next count so they line up with cnt_q.
        if (run) begin
            clkdv_d = (cnt_d < (div_d >> 1));
            ce_d    = (cnt_d == div_d - DIV_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= DIV_W'(clamp_div(DEFAULT_DIV));
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            act_q    <= 1'b0;
            clkdv_q  <= 1'b0;
            ce_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            act_q    <= run;
            clkdv_q  <= clkdv_d;
            ce_q     <= ce_d;
        end
    end

    assign clkdv = clkdv_q;
    assign ce    = ce_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider / clock-enable generator with a shared lock indicator.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                    CLKIN_IN,
    input  logic                    RST_IN,
    input  logic [NUM_CH*DIV_W-1:0] DIV_IN,
    input  logic [NUM_CH-1:0]       DIV_LOAD_IN,
    input  logic [NUM_CH-1:0]       EN_IN,
    output logic [NUM_CH-1:0]       CLKDV_OUT,
    output logic [NUM_CH-1:0]       CE_OUT,
    output logic                    LOCKED_OUT
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic [NUM_CH-1:0] run;

    // The counter freezes once locked; the flag stays set until reset.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            locked_d   = (lock_cnt_d == LOCK_W'(LOCK_CYCLES));
        end
    end

    always_ff @(posedge CLKIN_IN) begin
        if (RST_IN) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign LOCKED_OUT = locked_q;
    assign run        = {NUM_CH{locked_q}} & EN_IN;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk   (CLKIN_IN),
            .rst   (RST_IN),
            .run   (run[i]),
            .div   (DIV_IN[i*DIV_W +: DIV_W]),
            .load  (DIV_LOAD_IN[i]),
            .clkdv (CLKDV_OUT[i]),
            .ce    (CE_OUT[i])
        );
    end

endmodule
